// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay timer: per-channel period/mode, run/stop control,
// registered terminal pulse, run flag and sticky invariant-violation flag.
module multi_delay_timer #(
  parameter int NCH       = 4,
  parameter int CBITS     = 19,
  parameter int DEFAULT_N = 400000,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CBITS-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  output logic [NCH-1:0]   sig,
  output logic [NCH-1:0]   flg,
  output logic [NCH-1:0]   err,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | channel stopped, counter held, config writes apply directly
  // S_RUN  | channel counting towards P_act, config writes go to the shadow
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CBITS-1:0] P_RST = CBITS'(DEFAULT_N);

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CBITS-1:0] cnt_q   [NCH];
  logic [CBITS-1:0] cnt_d   [NCH];
  logic [CBITS-1:0] p_act_q [NCH];
  logic [CBITS-1:0] p_act_d [NCH];
  logic [CBITS-1:0] p_sh_q  [NCH];
  logic [CBITS-1:0] p_sh_d  [NCH];
  logic [NCH-1:0]   m_act_q, m_act_d;
  logic [NCH-1:0]   m_sh_q, m_sh_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   sig_q, sig_d;
  logic [NCH-1:0]   err_q, err_d;
  logic             busy_q, busy_d;

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      p_act_d[i] = p_act_q[i];
      p_sh_d[i]  = p_sh_q[i];
      m_act_d[i] = m_act_q[i];
      m_sh_d[i]  = m_sh_q[i];
      pend_d[i]  = pend_q[i];
      sig_d[i]   = 1'b0;
      err_d[i]   = err_q[i] | ((state_q[i] == S_RUN) && (cnt_q[i] > p_act_q[i]));

      case (state_q[i])
        S_IDLE: begin
          if (start[i]) begin
            state_d[i] = S_RUN;
            cnt_d[i]   = '0;
          end
        end
        S_RUN: begin
          if (stop[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (start[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == p_act_q[i]) begin
            sig_d[i] = 1'b1;
            cnt_d[i] = '0;
            if (pend_q[i]) begin
              p_act_d[i] = p_sh_q[i];
              m_act_d[i] = m_sh_q[i];
              pend_d[i]  = 1'b0;
            end
            // one-shot decision uses the mode that governed the period just ended
            if (m_act_q[i]) state_d[i] = S_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CBITS'(1);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase

      // out-of-range cfg_ch zero-extends to a value no channel index matches
      if (cfg_we && (int'(cfg_ch) == i)) begin
        if ((state_q[i] == S_IDLE) && !start[i]) begin
          p_act_d[i] = cfg_period;
          m_act_d[i] = cfg_oneshot;
          pend_d[i]  = 1'b0;
        end else begin
          p_sh_d[i] = cfg_period;
          m_sh_d[i] = cfg_oneshot;
          pend_d[i] = 1'b1;
        end
      end

      busy_d = busy_d | (state_d[i] == S_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        p_act_q[i] <= P_RST;
        p_sh_q[i]  <= P_RST;
      end
      m_act_q <= '0;
      m_sh_q  <= '0;
      pend_q  <= '0;
      sig_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        p_act_q[i] <= p_act_d[i];
        p_sh_q[i]  <= p_sh_d[i];
      end
      m_act_q <= m_act_d;
      m_sh_q  <= m_sh_d;
      pend_q  <= pend_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) flg[i] = (state_q[i] == S_RUN);
  end

  assign sig  = sig_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule
